// File: rtl/snn_pkg.sv
// Shared SNN core definitions: controller state encodings and core geometry.
package snn_pkg;

    localparam int N_NUM = 32;
    localparam int G_NUM = 8;
    localparam int N_SZ  = 5;
    localparam int G_SZ  = 3;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SET      = 3'd1;
    localparam logic [2:0] SYN_ACCU = 3'd2;
    localparam logic [2:0] DECAY    = 3'd3;
    localparam logic [2:0] PDE      = 3'd4;
    localparam logic [2:0] FINISH   = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

endpackage

// File: rtl/spike_out_reg.sv
// One-entry valid/ready holding register.
// A load may coincide with a drain of the previous word.
module spike_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (load) begin
                data <= load_data;
            end
            valid <= load | (valid & ~ready);
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Spike stream transmitter: packs two fire bits per beat during PDE
// into an N_NUM-bit word and hands it to the next layer's decoder.
module spike_encoder #(
    parameter int N_NUM = snn_pkg::N_NUM,
    parameter int N_SZ  = snn_pkg::N_SZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic             fire_valid,
    input  logic [1:0]       fire,
    input  logic [N_SZ-1:0]  rf_addr,
    output logic             fire_ready,
    output logic [N_NUM-1:0] spike_stream_out,
    output logic             stream_valid,
    input  logic             stream_ready,
    output logic             enc_fin,
    output logic             addr_err
);

    import snn_pkg::*;

    localparam int CW = N_SZ - 1;
    localparam logic [CW-1:0] LAST = CW'(N_NUM / 2 - 1);

    logic             pde;
    logic             pde_q;
    logic             entry;
    logic             last;
    logic             accept;
    logic             load;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_eff;
    logic [N_NUM-3:0] coll;
    logic [N_NUM-3:0] coll_eff;
    logic [N_NUM-1:0] word;

    assign pde      = (state == PDE);
    assign entry    = pde & ~pde_q;
    assign cnt_eff  = entry ? '0 : cnt;
    assign coll_eff = entry ? '0 : coll;
    assign last     = (cnt_eff == LAST);

    // Only the final beat can stall: it needs the output slot free.
    assign fire_ready = ~(last & stream_valid & ~stream_ready);
    assign accept     = pde & fire_valid & fire_ready;
    assign load       = accept & last;

    // Bits shifted past position 2 can never reach the word, so the
    // collector keeps only the upper N_NUM-2 bits of the shift chain.
    assign word = {fire, coll_eff};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pde_q    <= 1'b0;
            cnt      <= '0;
            coll     <= '0;
            enc_fin  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            pde_q   <= pde;
            enc_fin <= load;
            if (accept && rf_addr != {cnt_eff, 1'b0}) begin
                addr_err <= 1'b1;
            end
            if (!pde) begin
                cnt  <= '0;
                coll <= '0;
            end else if (accept) begin
                coll <= word[N_NUM-1:2];
                cnt  <= last ? '0 : cnt_eff + CW'(1);
            end else if (entry) begin
                cnt  <= '0;
                coll <= '0;
            end
        end
    end

    spike_out_reg #(
        .W(N_NUM)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (word),
        .ready     (stream_ready),
        .data      (spike_stream_out),
        .valid     (stream_valid)
    );

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: array-based reference model plus
// directed words with hand-computed packed results.
module tb_spike_encoder;

    import snn_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        fire_valid;
    logic [1:0]  fire;
    logic [4:0]  rf_addr;
    logic        fire_ready;
    logic [31:0] spike_stream_out;
    logic        stream_valid;
    logic        stream_ready;
    logic        enc_fin;
    logic        addr_err;

    always #5 clk = ~clk;

    spike_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .state            (state),
        .fire_valid       (fire_valid),
        .fire             (fire),
        .rf_addr          (rf_addr),
        .fire_ready       (fire_ready),
        .spike_stream_out (spike_stream_out),
        .stream_valid     (stream_valid),
        .stream_ready     (stream_ready),
        .enc_fin          (enc_fin),
        .addr_err         (addr_err)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: neuron bits placed by beat index into an array.
    int          m_k;
    logic [31:0] m_bits;
    logic [31:0] m_word;
    bit          m_valid;
    bit          m_fin;
    bit          m_err;
    bit          m_prev;
    bit          m_pde;
    bit          m_acc;
    bit          m_ld;

    function automatic bit m_fr();
        return !(m_k == 15 && m_valid && !stream_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_k = 0; m_bits = '0; m_word = '0;
            m_valid = 0; m_fin = 0; m_err = 0; m_prev = 0;
        end else begin
            m_pde = (state == PDE);
            if (m_pde && !m_prev) begin
                m_k = 0; m_bits = '0;
            end
            m_acc = m_pde && fire_valid && m_fr();
            m_ld  = 0;
            if (m_acc) begin
                if (rf_addr != 5'(2 * m_k)) m_err = 1;
                m_bits[2*m_k]   = fire[0];
                m_bits[2*m_k+1] = fire[1];
                m_k++;
                if (m_k == 16) begin
                    m_ld = 1; m_word = m_bits;
                    m_k = 0; m_bits = '0;
                end
            end
            if (m_ld) m_valid = 1;
            else if (m_valid && stream_ready) m_valid = 0;
            m_fin = m_ld;
            if (!m_pde) begin
                m_k = 0; m_bits = '0;
            end
            m_prev = m_pde;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && rst) begin
            chk("fire_ready", 32'(fire_ready), 32'(m_fr()));
            chk("stream_valid", 32'(stream_valid), 32'(m_valid));
            chk("spike_word", spike_stream_out, m_word);
            chk("enc_fin", 32'(enc_fin), 32'(m_fin));
            chk("addr_err", 32'(addr_err), 32'(m_err));
        end
    end

    task automatic send(input int a, input logic [1:0] f,
                        input logic [2:0] s);
        int n;
        n = 0;
        @(negedge clk);
        state = s; fire_valid = 1'b1; rf_addr = 5'(a); fire = f;
        #1;
        while (!fire_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end
    endtask

    task automatic idle(input logic [2:0] s);
        @(negedge clk);
        state = s; fire_valid = 1'b0; fire = 2'b00;
    endtask

    task automatic after_final(input string nm, input logic [31:0] w);
        @(posedge clk); #1;
        chk({nm, "_word"}, spike_stream_out, w);
        chk({nm, "_valid"}, 32'(stream_valid), 32'd1);
        chk({nm, "_fin"}, 32'(enc_fin), 32'd1);
        chk({nm, "_model"}, m_word, w);
    endtask

    initial begin
        rst = 1'b0; state = IDLE; fire_valid = 1'b0; fire = 2'b00;
        rf_addr = '0; stream_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_fire_ready", 32'(fire_ready), 32'd1);
        chk("rst_valid", 32'(stream_valid), 32'd0);
        chk("rst_word", spike_stream_out, 32'd0);
        chk("rst_fin", 32'(enc_fin), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        rst = 1'b1;
        chk_en = 1;
        idle(IDLE);

        // All beats fire neuron 2k
        for (int k = 0; k < 16; k++) send(2 * k, 2'b01, PDE);
        after_final("t2", 32'h5555_5555);
        idle(DECAY);
        @(posedge clk); #1;
        chk("t2_drop_valid", 32'(stream_valid), 32'd0);
        chk("t2_fin_pulse", 32'(enc_fin), 32'd0);
        chk("t2_hold_word", spike_stream_out, 32'h5555_5555);

        // Asynchronous reset in the middle of a word
        for (int k = 0; k < 5; k++) send(2 * k, 2'b11, PDE);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t1_word", spike_stream_out, 32'd0);
        chk("t1_valid", 32'(stream_valid), 32'd0);
        chk("t1_fin", 32'(enc_fin), 32'd0);
        chk("t1_err", 32'(addr_err), 32'd0);
        chk("t1_fire_ready", 32'(fire_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1; state = IDLE; fire_valid = 1'b0;
        idle(IDLE);

        // Only beat 3 fires both neurons 6 and 7
        for (int k = 0; k < 16; k++)
            send(2 * k, (k == 3) ? 2'b11 : 2'b00, PDE);
        after_final("t3", 32'h0000_00C0);
        idle(DECAY);

        // Backpressure across two passes
        @(negedge clk); stream_ready = 1'b0;
        for (int k = 0; k < 16; k++)
            send(2 * k, (k % 2 == 0) ? 2'b10 : 2'b01, PDE);
        after_final("t4a", 32'h6666_6666);
        idle(DECAY);
        for (int k = 0; k < 15; k++) send(2 * k, 2'b11, PDE);
        @(negedge clk);
        fire_valid = 1'b1; rf_addr = 5'd30; fire = 2'b11;
        #1;
        chk("t4_stall", 32'(fire_ready), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_stall_late", 32'(fire_ready), 32'd0);
        chk("t4_held_word", spike_stream_out, 32'h6666_6666);
        chk("t4_held_valid", 32'(stream_valid), 32'd1);
        @(negedge clk); stream_ready = 1'b1;
        #1;
        chk("t4_release", 32'(fire_ready), 32'd1);
        after_final("t4b", 32'hFFFF_FFFF);
        idle(DECAY);
        @(posedge clk); #1;
        chk("t4_drain", 32'(stream_valid), 32'd0);

        // Aborted partial word must leave no stale bits
        for (int k = 0; k < 7; k++) send(2 * k, 2'b11, PDE);
        idle(DECAY);
        idle(DECAY);
        for (int k = 0; k < 16; k++) send(2 * k, 2'b10, PDE);
        after_final("t5", 32'hAAAA_AAAA);
        chk("t5_err", 32'(addr_err), 32'd0);
        idle(DECAY);

        // Wrong address on beat 2
        for (int k = 0; k < 16; k++)
            send((k == 2) ? 6 : 2 * k, 2'b01, PDE);
        after_final("t6a", 32'h5555_5555);
        chk("t6_err", 32'(addr_err), 32'd1);
        idle(DECAY);
        for (int k = 0; k < 16; k++) send(2 * k, 2'b10, PDE);
        after_final("t6b", 32'hAAAA_AAAA);
        chk("t6_err_sticky", 32'(addr_err), 32'd1);
        idle(IDLE);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
